// File: rtl/eth_f_packet_client_pkt_cnt_tx.sv
// eth_f_packet_client_pkt_cnt_tx: wrapping packet counter published as paced 8-bit snapshots
// with a level-held valid; spacing keeps consecutive snapshots less than 128 apart.
module eth_f_packet_client_pkt_cnt_tx #(
  parameter int INC_W        = 2,
  parameter int PUB_THRESH   = 64,
  parameter int PUB_INTERVAL = 1024,
  parameter int HOLD_CYC     = 8,
  parameter int GAP_CYC      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_vld,
  input  logic [INC_W-1:0] inc,
  input  logic             cnt_clr,
  output logic             cnt_out_vld,
  output logic [7:0]       cnt_out,
  output logic             delta_err
);
  localparam int TW = $clog2(PUB_INTERVAL);
  localparam int PW = $clog2((HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC) + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t        state, state_nx;
  logic [7:0]    cnt_acc, acc_nx, last_pub, lp_nx, out_nx, delta, delta_nx, acc_inc;
  logic [TW-1:0] timer, timer_nx;
  logic [PW-1:0] phase, phase_nx;
  logic          clr_s1, clr_s2, clr_s3, clr_p, err_nx, expire, trig;

  assign acc_inc     = inc_vld ? 8'(inc) : 8'd0;
  assign delta       = cnt_acc - last_pub;
  assign delta_nx    = acc_nx - lp_nx;
  assign expire      = timer == TW'(PUB_INTERVAL - 1);
  assign trig        = state == IDLE && (delta >= 8'(PUB_THRESH) || (expire && delta != 8'd0));
  assign cnt_out_vld = state == HOLD;
  assign err_nx      = clr_p ? 1'b0 : delta_err | delta_nx[7];

  always_comb begin
    state_nx = state;
    acc_nx   = cnt_acc + acc_inc;
    lp_nx    = last_pub;
    out_nx   = cnt_out;
    timer_nx = timer;
    phase_nx = phase + 1'b1;
    if (clr_p) begin
      state_nx = GAP;
      acc_nx   = 8'd0;
      lp_nx    = 8'd0;
      out_nx   = 8'd0;
      timer_nx = '0;
      phase_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          phase_nx = '0;
          timer_nx = (trig || expire) ? '0 : timer + 1'b1;
          state_nx = trig ? HOLD : IDLE;
          lp_nx    = trig ? cnt_acc : last_pub;
          out_nx   = trig ? cnt_acc : cnt_out;
        end
        HOLD: begin
          state_nx = phase == PW'(HOLD_CYC - 1) ? GAP : HOLD;
          phase_nx = phase == PW'(HOLD_CYC - 1) ? '0 : phase + 1'b1;
        end
        GAP: begin
          state_nx = phase == PW'(GAP_CYC - 1) ? IDLE : GAP;
          phase_nx = phase == PW'(GAP_CYC - 1) ? '0 : phase + 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // clear crosses from the CSR domain; clr_p is a single registered pulse per rising level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
      clr_s3 <= 1'b0;
      clr_p  <= 1'b0;
    end else begin
      clr_s1 <= cnt_clr;
      clr_s2 <= clr_s1;
      clr_s3 <= clr_s2;
      clr_p  <= clr_s2 & ~clr_s3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_acc   <= 8'd0;
      last_pub  <= 8'd0;
      cnt_out   <= 8'd0;
      timer     <= '0;
      phase     <= '0;
      delta_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt_acc   <= acc_nx;
      last_pub  <= lp_nx;
      cnt_out   <= out_nx;
      timer     <= timer_nx;
      phase     <= phase_nx;
      delta_err <= err_nx;
    end
  end
endmodule

// File: doc/eth_f_packet_client_pkt_cnt_tx.md
# eth_f_packet_client_pkt_cnt_tx

Datapath-side producer of the packet-client statistics snapshot channel. It accumulates per-cycle packet increments into an 8-bit wrapping counter. It publishes that counter to the CSR-side 64-bit extender as an 8-bit value with a level-held valid, whose rising edge the extender captures after synchronization. Publishes are paced so consecutive snapshots never differ by 128 or more, which is what lets the extender detect wrap from a bit-7 falling transition.

## Interface
- INC_W, 2: width of per-cycle increment; max increment 2^INC_W-1.
- PUB_THRESH, 64: pending delta that forces a publish.
- PUB_INTERVAL, 1024: idle-timer period in cycles; expiry publishes if delta is nonzero.
- HOLD_CYC, 8: cycles cnt_out_vld is held high per publish.
- GAP_CYC, 8: minimum cycles cnt_out_vld is low after a publish.
- Constraint: PUB_THRESH + (HOLD_CYC+GAP_CYC+1)*(2^INC_W-1) ≤ 127. Defaults give 115.
- clk, in, 1: single clock, datapath domain.
- rst_n, in, 1: asynchronous, active-low reset.
- inc_vld, in, 1: increment qualifier.
- inc, in, INC_W: packets completed this cycle.
- cnt_clr, in, 1: clear request from the CSR domain, treated as asynchronous.
- cnt_out_vld, out, 1: snapshot valid, level-held.
- cnt_out, out, 8: snapshot value.
- delta_err, out, 1: sticky flag; a delta of 128 or more occurred, so the 128-spacing guarantee was violated.

## Operation
- Registers:
  - cnt_acc[7:0]: running count.
  - last_pub[7:0]: last published value.
  - delta = cnt_acc - last_pub, mod 256.
  - timer: counts up to PUB_INTERVAL.
  - phase counter: used for HOLD and GAP.
- Accumulate every cycle: cnt_acc <= cnt_acc + (inc_vld ? inc : 0), modulo 256. Accumulation continues in every state.
- cnt_clr path:
  - Synchronized with a 2-flop synchronizer, then rising-edge detected to form clr_p.
  - A level held high produces one clr_p.
- FSM states:
  - IDLE: timer increments. A publish is triggered when delta ≥ PUB_THRESH, or when the timer reaches PUB_INTERVAL-1 and delta ≠ 0. On a trigger: cnt_out <= cnt_acc, last_pub <= cnt_acc, cnt_out_vld <= 1, timer <= 0, go to HOLD. If the timer expires with delta = 0, the timer reloads to 0 and the FSM stays in IDLE.
  - HOLD: cnt_out_vld stays 1 and cnt_out is stable. After HOLD_CYC cycles: cnt_out_vld <= 0, go to GAP.
  - GAP: cnt_out_vld stays 0. After GAP_CYC cycles, go to IDLE. Triggers are not evaluated in GAP or HOLD; pending delta is carried over.
- The trigger snapshot is the registered cnt_acc. An increment arriving in the trigger cycle counts toward the next delta.
- delta_err: set when the next-state delta (cnt_acc_next - last_pub_next) has bit 7 set. Cleared only by reset or clr_p.
- clr_p, which has priority over every other event:
  - cnt_acc, last_pub, cnt_out, timer and delta_err are set to 0.
  - cnt_out_vld <= 0; the FSM goes to GAP with a fresh GAP_CYC count.
  - Any increment in the clr_p cycle is discarded.
  - A publish in progress is aborted and is not reissued. The next publish reflects post-clear counts only.
- Wrap: cnt_acc wraps 0xFF→0x00 silently. Because consecutive published values differ by at most 127, every wrap shows up at the extender as bit 7 going 1→0.

## Timing
- Reset values (async, on rst_n low): cnt_out_vld = 0, cnt_out = 0x00, delta_err = 0, FSM = IDLE, all counters 0.
- Trigger to vld: cnt_out_vld rises on the clock edge after the trigger cycle. cnt_out updates on the same edge.
- Valid shape: cnt_out_vld is high for exactly HOLD_CYC cycles, then low for at least GAP_CYC cycles. Minimum publish period is HOLD_CYC+GAP_CYC+1 cycles.
- cnt_out stability: constant from the rising edge of cnt_out_vld until the next publish or clear. It never changes while cnt_out_vld is high, except when clr_p arrives, which forces it to 0.
- cnt_clr to effect: clr_p acts 3 cycles after cnt_clr is first sampled high (2 synchronizer flops plus the edge register).
- Threshold bound: the worst-case latency from threshold to snapshot is HOLD_CYC+GAP_CYC+1 cycles, which is the basis of the parameter constraint.

## Test plan
- Reset, then a single inc=1 pulse, then idle for PUB_INTERVAL cycles → exactly one publish with cnt_out = 0x01 and vld high for 8 cycles; no further publishes afterward.
- inc=1 every cycle → first publish at cnt_out = 0x40; all later publishes spaced at least 17 cycles apart, consecutive cnt_out deltas ≤ 127, and delta_err = 0.
- inc=3 every cycle for 2000 cycles, with a model of the CSR extender attached → the extender's 64-bit total equals 6000, checked at the final publish after traffic stops.
- Assert cnt_clr mid-HOLD with a snapshot of 0x80 → within 3 cycles vld drops and cnt_out = 0x00; there is no vld edge for at least 8 cycles; the next publish reflects post-clear counts only.
- Force a violation by running with PUB_THRESH = 127 and inc = 3 continuously → delta_err sets and stays set until cnt_clr is applied.
- Deassert rst_n asynchronously mid-GAP with cnt_acc = 0x55 → all outputs are 0 immediately; after release, counting restarts from 0.
